// File: rtl/rng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_arb_pkg
// Description : Shared definitions for the random-number arbiter.
//               Holds the FSM state type and the default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_arb_pkg;

  localparam int NUM_REQ_DEFAULT   = 4;
  localparam int SIZE_BITS_DEFAULT = 10;

  // One transaction walks IDLE -> FIRE -> CAPTURE -> ACK -> IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

endpackage : rng_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin winner search. The search starts
//               at last_granted+1 and moves upward, wrapping to index 0.
// Ports       : req          - request vector
//               last_granted - index of the most recently served requester
//               winner       - index of the selected requester
//               any_req      - high when at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_granted,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic w_found;

  // Two passes instead of a modulo: first the indices above last_granted,
  // then the wrapped-around indices up to and including last_granted.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    any_req = |req;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && (j > int'(last_granted)) && req[j]) begin
        winner  = IDX_W'(j);
        w_found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && (j <= int'(last_granted)) && req[j]) begin
        winner  = IDX_W'(j);
        w_found = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rng_arbiter
// Description : Round-robin arbiter in front of an external random number
//               generator. Each served requester triggers the generator,
//               the resulting value is captured and a one-cycle grant pulse
//               marks the requester the value belongs to.
// Ports       : clk      - system clock, rising edge
//               resetN   - asynchronous active-low reset
//               req      - level request per requester
//               grant    - one-hot one-cycle grant pulse
//               rand_val - last captured random value
//               busy     - high while a transaction is in progress
//               rng_rise - trigger to the generator's rise input
//               rng_dout - generator output value
// Revision    : 1.0 - initial release
// ============================================================================
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int SIZE_BITS = SIZE_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SIZE_BITS-1:0] rand_val,
  output logic                 busy,
  output logic                 rng_rise,
  input  logic [SIZE_BITS-1:0] rng_dout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] c_grant_one = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   c_last_rst  = IDX_W'(NUM_REQ - 1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_last;
  logic                 r_rng_rise;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SIZE_BITS-1:0] r_rand_val;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req          (req),
    .last_granted (r_last),
    .winner       (w_winner),
    .any_req      (w_any_req)
  );

  // rng_rise and grant are registered one state ahead so that each is high
  // exactly while the FSM sits in FIRE and ACK respectively.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= c_last_rst;
      r_rng_rise <= 1'b0;
      r_grant    <= '0;
      r_rand_val <= '0;
    end else begin
      r_rng_rise <= 1'b0;
      r_grant    <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_winner;
            r_rng_rise <= 1'b1;
            r_state    <= FIRE;
          end
        end
        FIRE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          // The generator's value is valid the cycle after its rise edge.
          r_rand_val <= rng_dout;
          r_grant    <= c_grant_one << r_owner;
          r_state    <= ACK;
        end
        ACK: begin
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign rand_val = r_rand_val;
  assign rng_rise = r_rng_rise;
  assign busy     = (r_state != IDLE);

endmodule : rng_arbiter
`default_nettype wire

// File: tb/tb_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_arbiter
// Description : Self-checking bench for rng_arbiter. A transaction-level
//               reference model predicts every output each cycle; a small
//               behavioural generator answers rng_rise edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_arbiter;

  localparam int N  = 4;
  localparam int SB = 10;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [SB-1:0] rand_val;
  logic          busy;
  logic          rng_rise;
  logic [SB-1:0] rng_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;

  rng_arbiter #(
    .NUM_REQ   (N),
    .SIZE_BITS (SB)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .req      (req),
    .grant    (grant),
    .rand_val (rand_val),
    .busy     (busy),
    .rng_rise (rng_rise),
    .rng_dout (rng_dout)
  );

  always #5 clk = ~clk;

  // Behavioural generator: latches a new value on each rising edge of rise.
  logic gen_fixed = 1'b1;
  logic gen_prev  = 1'b0;
  always @(posedge clk) begin
    gen_prev <= rng_rise;
    if (rng_rise && !gen_prev)
      rng_dout <= gen_fixed ? SB'(137) : SB'($urandom_range(0, 255));
  end

  // Reference model: a transaction in flight is described by how many
  // cycles it has run (0 = none), who owns it and the last served index.
  int            m_age;
  int            m_owner;
  int            m_last;
  logic [SB-1:0] m_rand;

  int            cyc;
  int            g_cyc[$];
  logic [N-1:0]  g_val[$];
  int            rise_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age   = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_rand  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [SB-1:0] dout);
    if (m_age == 0) begin
      if (r != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (r[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_rand = dout;
      m_age  = 3;
    end else begin
      m_last = m_owner;
      m_age  = 0;
    end
  endtask

  task automatic check_outputs(input string pfx);
    logic [N-1:0] exp_g;
    exp_g = (m_age == 3) ? N'(1 << m_owner) : '0;
    check({pfx, "_grant"},    32'(grant),    32'(exp_g));
    check({pfx, "_rise"},     32'(rng_rise), 32'(m_age == 1));
    check({pfx, "_busy"},     32'(busy),     32'(m_age != 0));
    check({pfx, "_rand"},     32'(rand_val), 32'(m_rand));
    check({pfx, "_onehot"},   32'($countones(grant) <= 1), 32'd1);
  endtask

  // One clock: drive req, take the edge, advance the model, check outputs.
  task automatic cycle(input logic [N-1:0] r);
    logic [SB-1:0] d;
    req = r;
    d   = rng_dout;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs("cyc");
    if (grant != '0) begin
      g_cyc.push_back(cyc + 1);
      g_val.push_back(grant);
    end
    if (rng_rise && rise_cyc < 0) rise_cyc = cyc + 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    req    = '0;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    cyc      = 0;
    rise_cyc = -1;
    g_cyc.delete();
    g_val.delete();
  endtask

  initial begin
    @(negedge clk);

    // Single requester with a constant generator value.
    gen_fixed = 1'b1;
    do_reset();
    repeat (4) cycle(4'b0100);
    check("single_rise_cyc",  32'(rise_cyc), 32'd1);
    check("single_grant_cyc", 32'(g_cyc.size() > 0 ? g_cyc[0] : -1), 32'd3);
    check("single_grant_val", 32'(g_val.size() > 0 ? g_val[0] : 4'd0), 32'b0100);
    check("single_rand",      32'(rand_val), 32'd137);

    // All requesters continuously: 0,1,2,3,0 every 4 cycles.
    do_reset();
    repeat (20) cycle(4'b1111);
    check("all_count", 32'(g_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < g_cyc.size()) begin
        check("all_cyc", 32'(g_cyc[i]), 32'(3 + 4 * i));
        check("all_val", 32'(g_val[i]), 32'(1 << (i % 4)));
      end
    end

    // Request dropped right after being sampled.
    do_reset();
    cycle(4'b0010);
    repeat (5) cycle(4'b0000);
    check("drop_grant_cyc", 32'(g_cyc.size() > 0 ? g_cyc[0] : -1), 32'd3);
    check("drop_grant_val", 32'(g_val.size() > 0 ? g_val[0] : 4'd0), 32'b0010);
    check("drop_busy_end",  32'(busy), 32'd0);

    // Reset in the middle of CAPTURE, then re-arbitrate from requester 0.
    do_reset();
    repeat (2) cycle(4'b1000);
    check("mid_busy_before", 32'(busy), 32'd1);
    do_reset();
    check("mid_rand", 32'(rand_val), 32'd0);
    check("mid_none", 32'(g_cyc.size()), 32'd0);
    repeat (4) cycle(4'b1010);
    check("mid_first_grant", 32'(g_val.size() > 0 ? g_val[0] : 4'd0), 32'b0010);

    // Random requests with a randomising generator.
    gen_fixed = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (i % 2 == 0) r[0] = ~r[0];
      cycle(r);
      check("rnd_range", 32'(rand_val <= 255), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rng_arbiter
`default_nettype wire
